// File: rtl/shared_mem_arbiter.sv
// Two-port arbiter/sequencer sharing one single-port, variable-latency word
// memory between instruction fetch and the data stage. Data wins by default;
// a saturating starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants made while a fetch was waiting.
module shared_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  // data port
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  // memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Keep at least one bit so STARVE_LIMIT=0 still elaborates.
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} state_t;

  state_t        state;
  logic          we_q;      // latched direction of the granted access
  logic          done_if;   // DONE belongs to the fetch port
  logic [CW-1:0] starve_cnt;

  logic dm_req;
  logic fetch_win;

  // Byte-offset bits never reach the word memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

  assign dm_req    = dm_rd | dm_wr;
  assign fetch_win = if_req & (~dm_req | (starve_cnt == LIM));

  // Memory-side controls and completion pulses decode straight from state,
  // so reset clears them without waiting for a clock edge.
  assign mem_en   = (state == IF_BUSY) | (state == DM_BUSY);
  assign mem_we   = (state == DM_BUSY) & we_q;
  assign if_valid = (state == DONE) & done_if;
  assign dm_valid = (state == DONE) & ~done_if;

  // Grant, sequence and capture; mem_addr/mem_wdata are latched at the grant
  // edge and held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      done_if    <= 1'b0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_win) begin
            state      <= IF_BUSY;
            we_q       <= 1'b0;
            done_if    <= 1'b1;
            mem_addr   <= {if_addr[31:2], 2'b00};
            starve_cnt <= '0;
          end else if (dm_req) begin
            state     <= DM_BUSY;
            we_q      <= dm_wr;   // rd+wr together is treated as a write
            done_if   <= 1'b0;
            mem_addr  <= {dm_addr[31:2], 2'b00};
            mem_wdata <= dm_wdata;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        IF_BUSY: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            state    <= DONE;
          end
        end
        DM_BUSY: begin
          if (mem_ready) begin
            if (!we_q) dm_rdata <= mem_rdata;
            state <= DONE;
          end
        end
        default: state <= IDLE;   // DONE: one pulse, no grant
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a vector table of single
// transactions, then arbitration fairness, STARVE_LIMIT=0 and mid-access reset.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_rd, dm_wr;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_valid, dm_valid;
  logic        mem_en, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // second instance: fetch always wins a tie
  logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0;
  logic        if_valid0, dm_valid0, mem_en0, mem_we0, mem_ready0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // memory responder: mem_ready after rdy_delay wait cycles
  int          rdy_delay;
  logic [3:0]  wcnt;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  shared_mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata0), .if_valid(if_valid0),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata0), .dm_valid(dm_valid0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready0)
  );

  always @(posedge clk or posedge rst)
    if (rst)          wcnt <= '0;
    else if (!mem_en) wcnt <= '0;
    else              wcnt <= wcnt + 4'd1;

  assign mem_ready  = mem_en && (int'(wcnt) >= rdy_delay);
  assign mem_ready0 = mem_en0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_rd, dm_wr;
    logic [31:0] dm_addr, dm_wdata, rdata;
    int          delay;
    logic        exp_if;      // fetch port expected to be served
    logic [31:0] exp_maddr;
    logic        exp_we;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] m_if, m_dm;    // model of the held read-data registers

  // One transaction: requests presented in the IDLE cycle the call starts in.
  task automatic run_txn(input vec_t v);
    int en_cnt;
    if_req = v.if_req; if_addr = v.if_addr;
    dm_rd = v.dm_rd; dm_wr = v.dm_wr; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    mem_rdata = v.rdata; rdy_delay = v.delay;
    step();
    en_cnt = 0;
    for (int k = 0; k < 40 && mem_en; k++) begin
      en_cnt++;
      check("mem_addr", mem_addr, v.exp_maddr);
      check("mem_we", {31'd0, mem_we}, {31'd0, v.exp_we});
      if (v.exp_we) check("mem_wdata", mem_wdata, v.dm_wdata);
      step();
    end
    check("busy_cycles", en_cnt, v.delay + 1);
    if (v.exp_if) m_if = v.rdata;
    else if (!v.exp_we) m_dm = v.rdata;
    check("if_valid", {31'd0, if_valid}, {31'd0, v.exp_if});
    check("dm_valid", {31'd0, dm_valid}, {31'd0, ~v.exp_if});
    check("if_rdata", if_rdata, m_if);
    check("dm_rdata", dm_rdata, m_dm);
    if_req = 0; dm_rd = 0; dm_wr = 0;
    step();
    check("pulse_end", {30'd0, if_valid, dm_valid}, 32'd0);
    check("idle_en", {31'd0, mem_en}, 32'd0);
  endtask

  initial begin
    string exp_ord;
    int    n_i, n_d;

    vecs[0] = '{1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0, 32'h0, 32'hE3A0_0014, 0, 1'b1, 32'h0000_0004, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_2000, 32'h1111_1111, 3, 1'b0, 32'h0000_0400, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0403, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 32'h0000_0400, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_0055, 32'h2222_2222, 0, 1'b0, 32'h0000_0010, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 2, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'hA5A5_5A5A, 0, 1'b0, 32'h0000_0008, 1'b0};

    rst = 1; if_req = 0; dm_rd = 0; dm_wr = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0; rdy_delay = 0;
    m_if = 0; m_dm = 0;
    step(); step();
    check("rst_ctrl", {28'd0, mem_en, mem_we, if_valid, dm_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    rst = 0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Both ports continuously requesting: starvation counter forces fetch.
    exp_ord = "DDDDIDDDDI";
    if_req = 1; dm_rd = 1; if_addr = 32'h40; dm_addr = 32'h80;
    mem_rdata = 32'h0BAD_F00D; rdy_delay = 0;
    for (int t = 0; t < 10; t++) begin
      int k;
      for (k = 0; k < 10 && !(if_valid || dm_valid); k++) step();
      if (k == 10) begin
        check("arb_timeout", 32'd1, 32'd0);
      end else begin
        check($sformatf("arb_order%0d", t),
              {24'd0, (if_valid ? 8'h49 : 8'h44)}, {24'd0, exp_ord[t]});
        step();
      end
    end

    // STARVE_LIMIT=0 instance: every completion under a tie is a fetch.
    n_i = 0; n_d = 0;
    for (int c = 0; c < 12; c++) begin
      if (if_valid0) n_i++;
      if (dm_valid0) n_d++;
      step();
    end
    check("lim0_fetches", n_i, 4);
    check("lim0_data", n_d, 0);

    if_req = 0; dm_rd = 0;
    for (int c = 0; c < 4; c++) step();
    m_dm = 32'h0BAD_F00D; m_if = 32'h0BAD_F00D;

    // Reset in the second wait cycle of a data read.
    dm_rd = 1; dm_addr = 32'h20; mem_rdata = 32'h7777_7777; rdy_delay = 5;
    step();
    check("rr_busy1", {31'd0, mem_en}, 32'd1);
    step();
    check("rr_busy2", {31'd0, mem_en}, 32'd1);
    rst = 1; dm_rd = 0;
    #1;
    check("rr_ctrl", {28'd0, mem_en, mem_we, if_valid, dm_valid}, 32'd0);
    check("rr_mem_addr", mem_addr, 32'd0);
    check("rr_dm_rdata", dm_rdata, 32'd0);
    check("rr_if_rdata", if_rdata, 32'd0);
    m_if = 0; m_dm = 0;
    step(); step();
    rst = 0;
    n_d = 0;
    for (int c = 0; c < 6; c++) begin
      if (dm_valid) n_d++;
      step();
    end
    check("rr_no_dm_valid", n_d, 0);

    run_txn('{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0001, 0,
              1'b1, 32'h0000_0100, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Two-port arbiter and sequencer that lets the ARM pipeline's instruction-fetch stage and memory stage share one single-port, variable-latency word memory. It accepts one request per port, grants the memory to one port at a time, holds the transaction until the memory signals completion, and returns read data with a one-cycle valid pulse. Data accesses normally win, and a starvation counter guarantees fetch progress.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data-port grants while a fetch is pending (0 means fetch always wins a tie).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_valid.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction word.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_rd  in  1  data read request; held until dm_valid.
- dm_wr  in  1  data write request; held until dm_valid.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  write data.
- dm_rdata  out  32  read data.
- dm_valid  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access active.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, sampled only while mem_en=1.

## Operation
- States: IDLE, IF_BUSY, DM_BUSY, DONE.
- IDLE: sample the requests. The data request (dm_rd|dm_wr) wins unless if_req=1 and starve_cnt==STARVE_LIMIT.
  - Data granted -> DM_BUSY.
  - Fetch granted -> IF_BUSY.
  - No request -> stay in IDLE.
- Latch the granted port's address, direction and wdata into registers at the grant edge. mem_* are driven from these registers and stay stable for the whole transaction.
- mem_addr = {addr[31:2], 2'b00}.
- mem_we = 1 only for data writes. If dm_rd and dm_wr are both high, the access is a write.
- IF_BUSY/DM_BUSY: mem_en=1 until the cycle where mem_ready=1. At that edge:
  - Capture mem_rdata into if_rdata (fetch) or dm_rdata (data read).
  - Go to DONE.
  - Writes leave dm_rdata unchanged.
  - There is no timeout; the arbiter waits indefinitely.
- DONE: mem_en=0 and exactly one of if_valid/dm_valid is 1, then go to IDLE. No grant is made in DONE, so a requester can drop or replace its request before the next sample.
- starve_cnt, width clog2(STARVE_LIMIT+1), updated at each grant:
  - Data grant with if_req=1: saturating increment.
  - Data grant with if_req=0: clear.
  - Fetch grant: clear.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; mem_en, mem_we, if_valid, dm_valid = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starve_cnt = 0.
  - An in-flight memory access is abandoned and no valid pulse is produced for it.

## Timing
- All outputs are registered or decoded from state. There is no combinational path from a request or mem_ready to any output.
- Grant decision at the rising edge ending an IDLE cycle. mem_en rises the following cycle.
- Minimum latency, mem_ready high in the first busy cycle: request seen in cycle 0, mem_en in cycle 1, valid in cycle 2.
- Each additional wait cycle before mem_ready adds one cycle to the latency.
- Maximum throughput: one transaction per 3 cycles (IDLE, BUSY, DONE).
- if_rdata/dm_rdata hold their value until the next completed read on the same port.
- Requests that change while their port is not granted have no effect until the next IDLE sample.

## Test plan
- Reset, then if_req=1, if_addr=0x0000_0006, mem_ready tied high, mem_rdata=0xE3A0_0014:
  - mem_addr=0x0000_0004 in cycle 1.
  - if_valid pulse in cycle 2 with if_rdata=0xE3A0_0014.
- dm_wr=1, dm_addr=0x400, dm_wdata=0x2000, mem_ready delayed 3 cycles:
  - mem_en/mem_we high for 4 cycles.
  - dm_valid pulses once.
  - dm_rdata unchanged.
- if_req and dm_rd held high together for 10 transactions, STARVE_LIMIT=4:
  - Grant order D,D,D,D,I,D,D,D,D,I.
- STARVE_LIMIT=0 with simultaneous requests:
  - Fetch granted first every time.
- Assert rst in the second wait cycle of a data read:
  - All outputs go to 0 immediately and no dm_valid is produced.
  - After release, a new fetch completes normally with 2-cycle latency.
